board_vga_renderer: RTL

Pipelined, parametrised VGA pixel renderer for an ROWS×COLS grid-game board. It sits between the VGA timing generator and the RGB pins. It reads cell state from the game core through a one-cycle-latency read port and delays hsync/vsync to stay aligned with colour. Beyond static rendering, it flashes winning pieces with a frame-based period and runs a drop animation: a piece falls from the top of the board to its landing cell, with a start/busy/done handshake.

---
 rtl/board_vga_renderer.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/board_vga_renderer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// board_vga_renderer - 2-stage VGA renderer for a grid-game board with
// winning-piece flash and drop animation.                       Rev 1.0
// ---------------------------------------------------------------------------
module board_vga_renderer #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int CELL_LOG2    = 5,
  parameter int BOARD_X      = 192,
  parameter int BOARD_Y      = 112,
  parameter int CURSOR_GAP   = 16,
  parameter int FLASH_FRAMES = 30,
  parameter int ANIM_STEP    = 4
) (
  input  logic                     clk_25MHz,
  input  logic                     rst_n,
  input  logic [9:0]               x_count,
  input  logic [9:0]               y_count,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     frame_start,
  output logic [$clog2(ROWS)-1:0]  rd_row,
  output logic [$clog2(COLS)-1:0]  rd_col,
  input  logic [1:0]               rd_piece,
  input  logic                     rd_winning,
  input  logic [$clog2(COLS)-1:0]  current_col,
  input  logic [1:0]               current_player,
  input  logic [1:0]               winner,
  input  logic                     anim_start,
  input  logic [$clog2(COLS)-1:0]  anim_col,
  input  logic [$clog2(ROWS)-1:0]  anim_row,
  input  logic [1:0]               anim_player,
  output logic                     anim_busy,
  output logic                     anim_done,
  output logic                     vga_hsync,
  output logic                     vga_vsync,
  output logic [1:0]               vga_r,
  output logic [1:0]               vga_g,
  output logic [1:0]               vga_b
);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int FW   = $clog2(FLASH_FRAMES + 1);
  localparam int CELL = 1 << CELL_LOG2;
  localparam int DW   = CELL_LOG2 + 1;
  localparam int RAD  = CELL / 2 - 2;

  localparam logic signed [DW-1:0] HALF   = DW'(CELL / 2);
  localparam logic [2*DW:0]        RSQ    = (2*DW+1)'(RAD * RAD);
  localparam logic [9:0]           BX     = 10'(BOARD_X);
  localparam logic [9:0]           BY     = 10'(BOARD_Y);
  localparam logic [9:0]           CUR_Y0 = 10'(BOARD_Y - CURSOR_GAP - CELL);
  localparam logic [9:0]           BW     = 10'(COLS * CELL);
  localparam logic [9:0]           BH     = 10'(ROWS * CELL);
  localparam logic [9:0]           CELLV  = 10'(CELL);

  localparam logic [5:0] C_YEL  = 6'b111100;
  localparam logic [5:0] C_RED  = 6'b110000;
  localparam logic [5:0] C_BG   = 6'b011101;
  localparam logic [5:0] C_BLUE = 6'b000011;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FALL = 1'b1} state_t;

  function automatic logic circ_hit(input logic [CELL_LOG2-1:0] px,
                                    input logic [CELL_LOG2-1:0] py);
    logic signed [DW-1:0]   dx, dy;
    logic signed [2*DW-1:0] dxe, dye;
    logic [2*DW-1:0]        sx, sy;
    logic [2*DW:0]          sum;
    dx  = $signed({1'b0, px}) - HALF;
    dy  = $signed({1'b0, py}) - HALF;
    dxe = (2*DW)'(dx);
    dye = (2*DW)'(dy);
    sx  = $unsigned(dxe * dxe);
    sy  = $unsigned(dye * dye);
    sum = {1'b0, sx} + {1'b0, sy};
    return sum <= RSQ;
  endfunction

  function automatic logic [5:0] player_rgb(input logic [1:0] p);
    return (p == 2'b10) ? C_RED : C_YEL;
  endfunction

  state_t          state_q, state_d;
  logic [9:0]      anim_y_q, anim_y_d;
  logic [CW-1:0]   acol_q, acol_d;
  logic [RW-1:0]   arow_q, arow_d;
  logic [1:0]      aplayer_q, aplayer_d;
  logic            done_q, done_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            show_q, show_d;

  // Stage 0: address and geometry from the raw pixel position
  logic [9:0] ox, oy, cy, fy;
  logic       in_x, active_d, board_d, hole_d, cur_d, fall_d, acell_d;

  assign ox     = x_count - BX;
  assign oy     = y_count - BY;
  assign cy     = y_count - CUR_Y0;
  assign fy     = oy - anim_y_q;
  assign rd_col = CW'(ox >> CELL_LOG2);
  assign rd_row = RW'(ROWS - 1) - RW'(oy >> CELL_LOG2);

  assign in_x     = ox < BW;
  assign active_d = (x_count < 10'd640) && (y_count < 10'd480);
  assign board_d  = in_x && (oy < BH);
  assign hole_d   = circ_hit(ox[CELL_LOG2-1:0], oy[CELL_LOG2-1:0]);
  assign cur_d    = in_x && (rd_col == current_col) && (cy < CELLV) &&
                    circ_hit(ox[CELL_LOG2-1:0], cy[CELL_LOG2-1:0]);
  assign fall_d   = anim_busy && in_x && (rd_col == acol_q) && (fy < CELLV) &&
                    circ_hit(ox[CELL_LOG2-1:0], fy[CELL_LOG2-1:0]);
  assign acell_d  = anim_busy && (rd_col == acol_q) && (rd_row == arow_q);

  logic active_q, board_q, hole_q, cur_q, fall_q, acell_q;
  logic hs1_q, vs1_q;
  logic [5:0] rgb_q, rgb_d;

  always_comb begin
    logic vis;
    vis   = !(rd_winning && (winner != 2'b00) && !show_q) && !acell_q;
    rgb_d = 6'b000000;
    if (!active_q)                                      rgb_d = 6'b000000;
    else if (fall_q)                                    rgb_d = player_rgb(aplayer_q);
    else if (cur_q && !anim_busy && winner == 2'b00)    rgb_d = player_rgb(current_player);
    else if (board_q && hole_q && vis && rd_piece == 2'b01) rgb_d = C_YEL;
    else if (board_q && hole_q && vis && rd_piece == 2'b10) rgb_d = C_RED;
    else if (board_q && !hole_q)                        rgb_d = C_BLUE;
    else                                                rgb_d = C_BG;
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      board_q  <= 1'b0;
      hole_q   <= 1'b0;
      cur_q    <= 1'b0;
      fall_q   <= 1'b0;
      acell_q  <= 1'b0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      rgb_q    <= 6'b000000;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      active_q <= active_d;
      board_q  <= board_d;
      hole_q   <= hole_d;
      cur_q    <= cur_d;
      fall_q   <= fall_d;
      acell_q  <= acell_d;
      hs1_q    <= hsync_in;
      vs1_q    <= vsync_in;
      rgb_q    <= rgb_d;
      vga_hsync <= hs1_q;
      vga_vsync <= vs1_q;
    end
  end

  assign vga_r = rgb_q[5:4];
  assign vga_g = rgb_q[3:2];
  assign vga_b = rgb_q[1:0];

  // Flash: half-period of FLASH_FRAMES frames while a winner is shown
  always_comb begin
    fcnt_d = fcnt_q;
    show_d = show_q;
    if (winner == 2'b00) begin
      fcnt_d = '0;
      show_d = 1'b1;
    end else if (frame_start) begin
      if (fcnt_q == FW'(FLASH_FRAMES - 1)) begin
        fcnt_d = '0;
        show_d = !show_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  logic [9:0]  target;
  logic [10:0] step_sum;
  assign target   = 10'(RW'(ROWS - 1) - arow_q) << CELL_LOG2;
  assign step_sum = {1'b0, anim_y_q} + 11'(ANIM_STEP);

  always_comb begin
    state_d   = state_q;
    anim_y_d  = anim_y_q;
    acol_d    = acol_q;
    arow_d    = arow_q;
    aplayer_d = aplayer_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: if (anim_start) begin
        acol_d    = anim_col;
        arow_d    = anim_row;
        aplayer_d = anim_player;
        anim_y_d  = '0;
        state_d   = S_FALL;
      end
      S_FALL: if (frame_start) begin
        if (anim_y_q == target) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (step_sum >= {1'b0, target}) begin
          anim_y_d = target;
        end else begin
          anim_y_d = step_sum[9:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      anim_y_q  <= '0;
      acol_q    <= '0;
      arow_q    <= '0;
      aplayer_q <= 2'b00;
      done_q    <= 1'b0;
      fcnt_q    <= '0;
      show_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      anim_y_q  <= anim_y_d;
      acol_q    <= acol_d;
      arow_q    <= arow_d;
      aplayer_q <= aplayer_d;
      done_q    <= done_d;
      fcnt_q    <= fcnt_d;
      show_q    <= show_d;
    end
  end

  assign anim_busy = (state_q == S_FALL);
  assign anim_done = done_q;

endmodule
`default_nettype wire
